// File: rtl/floppy_seek_ctrl.sv
// Head-positioning sequencer for the Shugart floppy bus: sequences DIR/STEP for seek and recalibrate.
// Define FLOPPY_SEEK_DBL_STEP_EN for double-step mode (two STEP pulses per logical cylinder).
module floppy_seek_ctrl #(
    parameter int unsigned DIR_SETUP_CYC  = 50,
    parameter int unsigned STEP_PULSE_CYC = 150,
    parameter int unsigned STEP_RATE_CYC  = 150000,
    parameter int unsigned SETTLE_CYC     = 750000,
    parameter int unsigned MAX_TRACK      = 79
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_recal,
    input  logic [6:0] cmd_track,
    input  logic       trk00_n,
    output logic       step_n,
    output logic       dir_n,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [6:0] cur_track,
    output logic       trk_valid
);

`ifdef FLOPPY_SEEK_DBL_STEP_EN
    localparam int unsigned PULSES_PER_CYL = 2;
`else
    localparam int unsigned PULSES_PER_CYL = 1;
`endif
    localparam logic        LAST_PHASE  = (PULSES_PER_CYL == 2);
    localparam logic [6:0]  MAX_TRK     = 7'(MAX_TRACK);
    localparam logic [8:0]  RECAL_LIMIT = 9'(PULSES_PER_CYL * (MAX_TRACK + 1));
    localparam logic [31:0] DS_LOAD     = DIR_SETUP_CYC - 1;
    localparam logic [31:0] LO_LOAD     = STEP_PULSE_CYC - 1;
    localparam logic [31:0] HI_LOAD     = STEP_RATE_CYC - STEP_PULSE_CYC - 1;
    localparam logic [31:0] SETTLE_LOAD = SETTLE_CYC - 1;

    typedef enum logic [2:0] {
        IDLE, DIR_SETUP, STEP_LO, STEP_HI, SETTLE, FINISH
    } state_t;

    state_t      state, state_nxt;
    logic [31:0] tmr, tmr_nxt;
    logic [6:0]  track_q, track_nxt;
    logic [6:0]  tgt_q, tgt_nxt;
    logic [8:0]  pulses_q, pulses_nxt;
    logic        valid_q, valid_nxt;
    logic        dir_q, dir_nxt;
    logic        recal_q, recal_nxt;
    logic        err_q, err_nxt;
    logic        phase_q, phase_nxt;
    logic        step_q;
    logic        trk_meta, trk_sync;
    logic        trk00;
    logic        tmr_done;
    logic        start_step;

    assign trk00    = ~trk_sync;
    assign tmr_done = (tmr == '0);

    always_comb begin
        // NOTE: every variable gets a default first so no path through the case infers a latch.
        state_nxt  = state;
        tmr_nxt    = tmr_done ? '0 : tmr - 32'd1;
        track_nxt  = track_q;
        tgt_nxt    = tgt_q;
        pulses_nxt = pulses_q;
        valid_nxt  = valid_q;
        dir_nxt    = dir_q;
        recal_nxt  = recal_q;
        err_nxt    = err_q;
        phase_nxt  = phase_q;
        start_step = 1'b0;

        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    tgt_nxt    = cmd_track;
                    recal_nxt  = cmd_recal;
                    err_nxt    = 1'b0;
                    pulses_nxt = '0;
                    phase_nxt  = 1'b0;
                    if (cmd_recal) begin
                        dir_nxt   = 1'b1;
                        valid_nxt = 1'b0;
                        state_nxt = DIR_SETUP;
                        tmr_nxt   = DS_LOAD;
                    end else if (!valid_q || cmd_track > MAX_TRK) begin
                        err_nxt   = 1'b1;
                        state_nxt = FINISH;
                    end else if (cmd_track == track_q) begin
                        state_nxt = FINISH;
                    end else begin
                        dir_nxt   = (cmd_track < track_q);
                        state_nxt = DIR_SETUP;
                        tmr_nxt   = DS_LOAD;
                    end
                end
            end
            DIR_SETUP, STEP_HI: begin
                if (tmr_done) begin
                    if (recal_q) begin
                        // TRK00 is only trusted at step boundaries, never mid-pulse.
                        if (trk00) begin
                            track_nxt = '0;
                            valid_nxt = 1'b1;
                            state_nxt = (pulses_q == '0) ? FINISH : SETTLE;
                            tmr_nxt   = SETTLE_LOAD;
                        end else if (pulses_q == RECAL_LIMIT) begin
                            err_nxt   = 1'b1;
                            track_nxt = '0;
                            valid_nxt = 1'b0;
                            state_nxt = FINISH;
                        end else begin
                            start_step = 1'b1;
                        end
                    end else if (state == STEP_HI && track_q == tgt_q && phase_q == 1'b0) begin
                        state_nxt = SETTLE;
                        tmr_nxt   = SETTLE_LOAD;
                    end else begin
                        start_step = 1'b1;
                    end
                end
            end
            STEP_LO: begin
                if (tmr_done) begin
                    state_nxt = STEP_HI;
                    tmr_nxt   = HI_LOAD;
                end
            end
            SETTLE: begin
                if (tmr_done) state_nxt = FINISH;
            end
            FINISH:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase

        // The cylinder count moves on the falling STEP edge of the last pulse of a cylinder.
        if (start_step) begin
            state_nxt  = STEP_LO;
            tmr_nxt    = LO_LOAD;
            pulses_nxt = pulses_q + 9'd1;
            phase_nxt  = (phase_q == LAST_PHASE) ? 1'b0 : 1'b1;
            if (!recal_q && phase_q == LAST_PHASE)
                track_nxt = dir_q ? track_q - 7'd1 : track_q + 7'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            tmr      <= '0;
            track_q  <= '0;
            tgt_q    <= '0;
            pulses_q <= '0;
            valid_q  <= 1'b0;
            dir_q    <= 1'b1;
            recal_q  <= 1'b0;
            err_q    <= 1'b0;
            phase_q  <= 1'b0;
            step_q   <= 1'b1;
            trk_meta <= 1'b1;
            trk_sync <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge values.
            state    <= state_nxt;
            tmr      <= tmr_nxt;
            track_q  <= track_nxt;
            tgt_q    <= tgt_nxt;
            pulses_q <= pulses_nxt;
            valid_q  <= valid_nxt;
            dir_q    <= dir_nxt;
            recal_q  <= recal_nxt;
            err_q    <= err_nxt;
            phase_q  <= phase_nxt;
            step_q   <= (state_nxt != STEP_LO);
            trk_meta <= trk00_n;
            trk_sync <= trk_meta;
        end
    end

    assign step_n    = step_q;
    assign dir_n     = dir_q;
    assign cmd_ready = (state == IDLE);
    assign busy      = (state != IDLE) && (state != FINISH);
    assign done      = (state == FINISH);
    assign err       = (state == FINISH) && err_q;
    assign cur_track = track_q;
    assign trk_valid = valid_q;

endmodule

// File: doc/floppy_seek_ctrl.md
# floppy_seek_ctrl

Head-positioning sequencer for the Shugart floppy bus. It accepts seek and recalibrate commands, then drives the active-low STEP and DIR bus pins with programmable pulse width, step rate, direction setup and head-settle times. It tracks the current cylinder and monitors TRK00 through a synchroniser. It sits between the command logic and the bus pin drivers, owning the only writes to STEP and DIR.

## Interface
- DIR_SETUP_CYC, 50: cycles DIR is held stable before the first STEP falling edge
- STEP_PULSE_CYC, 150: STEP low width in cycles
- STEP_RATE_CYC, 150000: cycles from one STEP falling edge to the next; must exceed STEP_PULSE_CYC
- SETTLE_CYC, 750000: head-settle cycles after the last step
- MAX_TRACK, 79: highest legal cylinder
- clk  in  1  system clock (PLL output, 50 MHz)
- rst  in  1  reset, asynchronous and active-high
- cmd_valid  in  1  command request
- cmd_ready  out  1  high only in IDLE
- cmd_recal  in  1  1 = recalibrate, 0 = seek to cmd_track
- cmd_track  in  7  target cylinder
- trk00_n  in  1  TRK00 from drive, active low, asynchronous
- step_n  out  1  STEP pin, active low
- dir_n  out  1  DIR pin; 0 = inward (track+1), 1 = outward
- busy  out  1  command in progress
- done  out  1  one-cycle completion pulse
- err  out  1  one-cycle pulse coincident with done on failure
- cur_track  out  7  current cylinder
- trk_valid  out  1  cur_track is known

## Operation
- Reset values:
  - step_n=1, dir_n=1, busy=0, done=0, err=0, cur_track=0, trk_valid=0, cmd_ready=1.
  - All timers and the state machine are cleared.
- trk00_n passes through a 2-flop synchroniser. trk00 = ~synchronised value.
- State machine states: IDLE, DIR_SETUP, STEP_LO, STEP_HI, SETTLE, FINISH.
- A command is accepted when cmd_valid && cmd_ready. Inputs are captured that cycle and busy=1 on the next cycle.
- Seek rejection: a seek with trk_valid=0 or cmd_track>MAX_TRACK goes straight to FINISH with err. No STEP pulses, and cur_track is unchanged.
- Seek to the same track: cmd_track==cur_track goes to FINISH with no steps and no settle.
- Seek otherwise:
  - dir_n = (cmd_track<cur_track).
  - DIR_SETUP lasts DIR_SETUP_CYC.
  - Each step is STEP_LO (STEP_PULSE_CYC) followed by STEP_HI (STEP_RATE_CYC−STEP_PULSE_CYC).
  - cur_track is updated ±1 on the cycle step_n falls.
  - After the STEP_HI following the final step: SETTLE (SETTLE_CYC), then FINISH.
- Recal:
  - dir_n=1, then DIR_SETUP.
  - Before each step (end of DIR_SETUP or STEP_HI), sample trk00. If set: cur_track=0, trk_valid=1, go to SETTLE. If trk00 is set at the first check, go to FINISH without settle.
  - After MAX_TRACK+1 steps with trk00 never seen: FINISH with err, trk_valid=0, cur_track=0.
- FINISH: done=1 for one cycle and busy=0 in the same cycle. The state returns to IDLE, so cmd_ready=1 on the next cycle.
- cmd_valid during busy is ignored (not queued).
- dir_n is only changed in IDLE or on command accept. It never changes while step_n=0.

## Timing
- Accept to first STEP falling edge: 1 + DIR_SETUP_CYC cycles.
- A seek of N>0 steps, from accept to done, takes 1 + DIR_SETUP_CYC + N·STEP_RATE_CYC + SETTLE_CYC cycles (±1 for FINISH).
- TRK00 reaction latency: 2 sync cycles plus the next step-boundary check.
- Reset mid-pulse: step_n returns to 1 asynchronously. No partial pulse resumes. trk_valid=0 afterwards.
- Timer width: 32 bits. Parameters up to 2^32−1 are legal.

## Configuration
- FLOPPY_SEEK_DBL_STEP_EN defined:
  - Double-step mode for 40-track media in 80-track drives.
  - Each logical cylinder issues two STEP pulses.
  - cur_track changes by 1 on the second falling edge only.
  - The recal step limit becomes 2·(MAX_TRACK+1) pulses.
- FLOPPY_SEEK_DBL_STEP_EN undefined: one pulse per cylinder, as described above.

## Test plan
All scenarios use DIR_SETUP_CYC=3, STEP_PULSE_CYC=2, STEP_RATE_CYC=10, SETTLE_CYC=20, MAX_TRACK=79.
- Reset then seek 5 -> done with err=1, zero pulses, trk_valid stays 0.
- trk00_n low, recal -> zero pulses, done with err=0, cur_track=0, trk_valid=1. Then seek 3 -> dir_n=0, 3 pulses of width 2 at period 10, first falling edge 4 cycles after accept, done at cycle 54±1, cur_track=3.
- From track 3, seek 1 -> dir_n=1 set before the first pulse, 2 pulses, cur_track=1. Seek 1 again -> done within 2 cycles with no pulses.
- trk00_n held high, recal -> exactly 80 pulses, then err=1, trk_valid=0.
- Assert rst while step_n=0 mid-seek -> step_n=1 immediately, outputs at reset values, next cmd_ready=1.
- With FLOPPY_SEEK_DBL_STEP_EN defined, seek 0->2 -> 4 pulses, cur_track=2. Seek to 80 -> err with no pulses.
